// File: rtl/barrel_shifter_pkg.sv
// Shared mode codes and sizing helper for the pipelined barrel shifter.
package barrel_shifter_pkg;

    localparam logic [1:0] MODE_ROL = 2'b00;
    localparam logic [1:0] MODE_ROR = 2'b01;
    localparam logic [1:0] MODE_SLL = 2'b10;
    localparam logic [1:0] MODE_SRL = 2'b11;

    function automatic int shamt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One shifter level: conditional shift by SHIFT, then a valid/data register slot.
module barrel_shift_stage
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHIFT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic             shift_en,
    input  logic [1:0]       mode,
    input  logic             down_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] y,
    output logic             zero_next
);

    logic             advance;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = x;
        if (shift_en) begin
            case (mode)
                MODE_ROL: shifted = (x << SHIFT) | (x >> (WIDTH - SHIFT));
                MODE_ROR: shifted = (x >> SHIFT) | (x << (WIDTH - SHIFT));
                MODE_SLL: shifted = x << SHIFT;
                default:  shifted = x >> SHIFT;
            endcase
        end
    end

    assign zero_next = (shifted == '0);

    // Slot may load when empty or when its occupant is leaving this cycle.
    assign advance = !out_valid || down_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
        end else if (advance) begin
            out_valid <= in_valid;
            if (in_valid) begin
                y <= shifted;
            end
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter (ROL/ROR/SLL/SRL), one stage per shift power, valid/ready.
// Optional y_zero output enabled by PIPELINED_BARREL_SHIFTER_ZERO_FLAG_EN.
module pipelined_barrel_shifter
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = shamt_width(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [SHAMT_W-1:0] sel,
    input  logic [1:0]         mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   y
`ifdef PIPELINED_BARREL_SHIFTER_ZERO_FLAG_EN
    ,
    output logic               y_zero
`endif
);

    logic [SHAMT_W-1:0] vld;
    logic [SHAMT_W-1:0] adv;
    logic [SHAMT_W-1:0] zero_next;
    logic [WIDTH-1:0]   data_p [SHAMT_W];
    logic [SHAMT_W-1:0] sel_p  [SHAMT_W-1];
    logic [1:0]         mode_p [SHAMT_W-1];
    logic               unused_bits;

    // Ready ripples back from the output; any empty slot downstream lets a stage move.
    always_comb begin
        adv = '0;
        adv[SHAMT_W-1] = out_ready || !vld[SHAMT_W-1];
        for (int k = SHAMT_W - 2; k >= 0; k--) begin
            adv[k] = adv[k+1] || !vld[k];
        end
    end

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        logic               v_in;
        logic [WIDTH-1:0]   d_in;
        logic [SHAMT_W-1:0] s_in;
        logic [1:0]         m_in;
        logic               down_ready;

        if (k == 0) begin : g_head
            assign v_in = in_valid;
            assign d_in = x;
            assign s_in = sel;
            assign m_in = mode;
        end else begin : g_body
            assign v_in = vld[k-1];
            assign d_in = data_p[k-1];
            assign s_in = sel_p[k-1];
            assign m_in = mode_p[k-1];
        end

        if (k == SHAMT_W - 1) begin : g_tail
            assign down_ready = out_ready;
        end else begin : g_link
            assign down_ready = adv[k+1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sel_p[k]  <= '0;
                    mode_p[k] <= MODE_ROL;
                end else if (adv[k] && v_in) begin
                    sel_p[k]  <= s_in;
                    mode_p[k] <= m_in;
                end
            end
        end

        barrel_shift_stage #(
            .WIDTH(WIDTH),
            .SHIFT(1 << k)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (v_in),
            .x         (d_in),
            .shift_en  (s_in[k]),
            .mode      (m_in),
            .down_ready(down_ready),
            .out_valid (vld[k]),
            .y         (data_p[k]),
            .zero_next (zero_next[k])
        );
    end

    assign unused_bits = ^{zero_next, g_stage[SHAMT_W-1].s_in};

    assign in_ready  = adv[0];
    assign out_valid = vld[SHAMT_W-1];
    assign y         = data_p[SHAMT_W-1];

`ifdef PIPELINED_BARREL_SHIFTER_ZERO_FLAG_EN
    // Flag is captured with the final stage's data so it stalls exactly like y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_zero <= 1'b0;
        end else if (adv[SHAMT_W-1] && vld[SHAMT_W-2]) begin
            y_zero <= zero_next[SHAMT_W-1];
        end
    end
`endif

endmodule
